// File: rtl/setpoint_pkg.sv
// Shared constants for the keypad setpoint entry block: key codes,
// FSM state encoding and default parameter values.
package setpoint_pkg;

    localparam int unsigned SP_MIN_DEF      = 10;
    localparam int unsigned SP_MAX_DEF      = 90;
    localparam int unsigned SP_RESET_DEF    = 25;
    localparam int unsigned TIMEOUT_CYC_DEF = 50_000_000;

    // Codes 0..9 are digits; the rest are command keys.
    localparam logic [3:0] KEY_ENTER = 4'd10;
    localparam logic [3:0] KEY_CLEAR = 4'd11;
    localparam logic [3:0] KEY_BKSP  = 4'd12;
    localparam logic [3:0] KEY_UP    = 4'd13;
    localparam logic [3:0] KEY_DOWN  = 4'd14;
    localparam logic [3:0] KEY_NONE  = 4'd15;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ENTRY = 1'b1
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/key_event_sync.sv
// Two-flop synchronizer for an active-low async strobe plus its data bus,
// followed by a falling-edge detector producing a one-cycle event.
// The detector stays disarmed after reset until the synchronized strobe
// has been seen high, so a strobe held low through reset release never
// produces an event.
module key_event_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         async_n_i,
    input  logic [W-1:0] data_i,
    output logic         event_o,
    output logic [W-1:0] data_o
);

    logic         vn_s1_q, vn_s2_q, vn_prev_q;
    logic [1:0]   fill_q;
    logic         armed_q;
    logic [W-1:0] d_s1_q, d_s2_q;

    // Synchronizer chain, edge-detect history and post-reset arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vn_s1_q   <= 1'b1;
            vn_s2_q   <= 1'b1;
            vn_prev_q <= 1'b1;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
            d_s1_q    <= '0;
            d_s2_q    <= '0;
        end else begin
            vn_s1_q   <= async_n_i;
            vn_s2_q   <= vn_s1_q;
            vn_prev_q <= vn_s2_q;
            fill_q    <= {fill_q[0], 1'b1};
            // vn_s2_q only carries a real input sample once fill_q[1] is set.
            armed_q   <= armed_q | (fill_q[1] & vn_s2_q);
            d_s1_q    <= data_i;
            d_s2_q    <= d_s1_q;
        end
    end

    assign event_o = armed_q & vn_prev_q & ~vn_s2_q;
    assign data_o  = d_s2_q;

endmodule

// File: rtl/setpoint_entry.sv
// Keypad setpoint entry: collects up to two BCD digits, commits them on
// ENTER when within [SP_MIN, SP_MAX], supports UP/DOWN nudging, CLEAR,
// BACKSPACE and an inactivity timeout that discards a pending entry.
module setpoint_entry
    import setpoint_pkg::*;
#(
    parameter int unsigned SP_MIN      = SP_MIN_DEF,
    parameter int unsigned SP_MAX      = SP_MAX_DEF,
    parameter int unsigned SP_RESET    = SP_RESET_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    input  logic       key_valid_n,
    output logic [6:0] setpoint,
    output logic       sp_update,
    output logic       err,
    output logic       entry_active,
    output logic [3:0] entry_tens,
    output logic [3:0] entry_ones,
    output logic [1:0] digit_count,
    output state_t     state_dbg
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          key_evt;
    logic [3:0]    key_val;

    state_t        state_q, state_d;
    logic [3:0]    tens_q, tens_d, ones_q, ones_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [6:0]    sp_q, sp_d;
    logic          upd_q, upd_d, err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [6:0]    value;
    logic          clr;

    key_event_sync #(.W(4)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_n_i (key_valid_n),
        .data_i    (key_code),
        .event_o   (key_evt),
        .data_o    (key_val)
    );

    assign value = {3'b000, tens_q} * 7'd10 + {3'b000, ones_q};

    // Next-state logic: key events take priority over the timeout.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        cnt_d   = cnt_q;
        sp_d    = sp_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        tmo_d   = tmo_q;
        clr     = 1'b0;
        if (key_evt) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (is_digit(key_val)) begin
                        tens_d  = 4'd0;
                        ones_d  = key_val;
                        cnt_d   = 2'd1;
                        state_d = ST_ENTRY;
                    end else begin
                        case (key_val)
                            KEY_ENTER, KEY_BKSP: err_d = 1'b1;
                            KEY_CLEAR:           clr   = 1'b1;
                            KEY_UP: begin
                                if (sp_q < 7'(SP_MAX)) begin
                                    sp_d  = sp_q + 7'd1;
                                    upd_d = 1'b1;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            KEY_DOWN: begin
                                if (sp_q > 7'(SP_MIN)) begin
                                    sp_d  = sp_q - 7'd1;
                                    upd_d = 1'b1;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ENTRY: begin
                    if (is_digit(key_val)) begin
                        if (cnt_q == 2'd1) begin
                            tens_d = ones_q;
                            ones_d = key_val;
                            cnt_d  = 2'd2;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        case (key_val)
                            KEY_ENTER: begin
                                if (value >= 7'(SP_MIN) && value <= 7'(SP_MAX)) begin
                                    sp_d  = value;
                                    upd_d = 1'b1;
                                end else begin
                                    err_d = 1'b1;
                                end
                                clr = 1'b1;
                            end
                            KEY_CLEAR: clr = 1'b1;
                            KEY_BKSP: begin
                                if (cnt_q == 2'd2) begin
                                    ones_d = tens_q;
                                    tens_d = 4'd0;
                                    cnt_d  = 2'd1;
                                end else begin
                                    clr = 1'b1;
                                end
                            end
                            KEY_UP, KEY_DOWN: err_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: clr = 1'b1;
            endcase
        end else if (state_q == ST_ENTRY) begin
            if (tmo_q == TW'(TIMEOUT_CYC)) begin
                clr   = 1'b1;
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
        if (clr) begin
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            cnt_d   = 2'd0;
            state_d = ST_IDLE;
        end
    end

    // State, entry buffer, committed setpoint, pulses and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            cnt_q   <= 2'd0;
            sp_q    <= 7'(SP_RESET);
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign setpoint     = sp_q;
    assign sp_update    = upd_q;
    assign err          = err_q;
    assign entry_active = (state_q == ST_ENTRY);
    assign entry_tens   = tens_q;
    assign entry_ones   = ones_q;
    assign digit_count  = cnt_q;
    assign state_dbg    = state_q;

endmodule
